// File: rtl/i2s_cap_pkg.sv
// Shared definitions for the I2S triggered capture block: FSM state encoding,
// trigger slope constants and the stereo frame width helper.
package i2s_cap_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        READOUT   = 3'd4
    } cap_state_t;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    // One stored frame is {left, right}.
    function automatic int frame_w(input int sample_width);
        return 2 * sample_width;
    endfunction

endpackage

// File: rtl/i2s_cap_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read with read
// enable so the output holds while the readout pipeline is stalled.
module i2s_cap_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/i2s_trig_capture.sv
// Triggered stereo capture behind the I2S receiver: pre-trigger ring buffer,
// level-crossing trigger and valid/ready readout. Optional: I2S_CAP_FRAME_CNT_EN.
module i2s_trig_capture
    import i2s_cap_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 32,
    parameter int DEPTH        = 256,
    parameter int PRE_DEPTH    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sel_lr,
    input  logic                    arm,
    input  logic                    force_trig,
    input  logic [SAMPLE_WIDTH-1:0] trig_level,
    input  logic                    trig_slope,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [SAMPLE_WIDTH-1:0] rd_data_l,
    output logic [SAMPLE_WIDTH-1:0] rd_data_r,
    output logic                    rd_last,
    output logic [2:0]              state_o,
`ifdef I2S_CAP_FRAME_CNT_EN
    output logic [31:0]             trig_frame_o,
`endif
    output logic                    busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = frame_w(SAMPLE_WIDTH);
    localparam logic [AW-1:0] PRE_C   = AW'(PRE_DEPTH);
    localparam logic [AW-1:0] PRE_M1  = AW'(PRE_DEPTH - 1);
    localparam logic [AW-1:0] POST_C  = AW'(DEPTH - PRE_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    cap_state_t state, state_nx;

    logic                           sel_q, pend, force_pend, ram_vld;
    logic signed [SAMPLE_WIDTH-1:0] l_hold, prev_l, level_s;
    logic [AW-1:0]                  wr_ptr, rd_ptr, trig_ptr, pre_cnt, post_cnt, rd_start_ptr;
    logic [CW-1:0]                  rd_cnt, out_cnt;
    logic [FW-1:0]                  ram_q;
    logic word_ev, left_ev, right_ev, frame_stb, wr_en, crossed;
    logic trig_hit, start_rd, rd_issue, rd_load, rd_xfer;

    assign word_ev   = sel_lr != sel_q;
    assign left_ev   = word_ev & sel_lr;
    assign right_ev  = word_ev & ~sel_lr;
    assign frame_stb = right_ev & pend;
    assign wr_en     = frame_stb & (state == ARMED || state == WAIT_TRIG || state == POST);
    assign level_s   = trig_level;
    assign crossed   = (trig_slope == SLOPE_RISE) ? (prev_l < level_s && l_hold >= level_s)
                                                  : (prev_l > level_s && l_hold <= level_s);
    assign rd_start_ptr = ((state == WAIT_TRIG) ? wr_ptr : trig_ptr) - PRE_C;

    assign rd_xfer  = rd_valid & rd_ready;
    assign rd_load  = ram_vld & (~rd_valid | rd_ready);
    assign rd_issue = (state == READOUT) && (rd_cnt != '0) && (!ram_vld || rd_load);

    assign state_o = state;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        trig_hit = 1'b0;
        start_rd = 1'b0;
        case (state)
            IDLE:      if (arm) state_nx = ARMED;
            ARMED:     if (frame_stb && pre_cnt == PRE_M1) state_nx = WAIT_TRIG;
            WAIT_TRIG: if (frame_stb && (crossed || force_pend || force_trig)) begin
                trig_hit = 1'b1;
                if (POST_C == '0) begin
                    state_nx = READOUT;
                    start_rd = 1'b1;
                end else begin
                    state_nx = POST;
                end
            end
            POST:      if (frame_stb && post_cnt == AW'(1)) begin
                state_nx = READOUT;
                start_rd = 1'b1;
            end
            READOUT:   if (rd_xfer && rd_last) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Word pairing, ring write pointer and trigger bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 1'b0;
            pend       <= 1'b0;
            l_hold     <= '0;
            prev_l     <= '0;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_ptr   <= '0;
            force_pend <= 1'b0;
        end else begin
            sel_q <= sel_lr;
            if (state == IDLE && arm) pend <= 1'b0;
            else if (left_ev)         pend <= 1'b1;
            else if (frame_stb)       pend <= 1'b0;
            if (left_ev) l_hold <= sample_in;
            if (frame_stb && state != READOUT) prev_l <= l_hold;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (state == IDLE && arm)            pre_cnt <= '0;
            else if (state == ARMED && frame_stb) pre_cnt <= pre_cnt + 1'b1;
            if (trig_hit) begin
                trig_ptr <= wr_ptr;
                post_cnt <= POST_C;
            end else if (state == POST && frame_stb) begin
                post_cnt <= post_cnt - 1'b1;
            end
            force_pend <= (state == WAIT_TRIG) && !trig_hit && (force_pend || force_trig);
        end
    end

    // RAM output acts as a prefetch stage ahead of the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            ram_vld   <= 1'b0;
            out_cnt   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data_l <= '0;
            rd_data_r <= '0;
        end else begin
            if (start_rd) begin
                rd_ptr  <= rd_start_ptr;
                rd_cnt  <= DEPTH_C;
                ram_vld <= 1'b0;
                out_cnt <= '0;
            end else begin
                if (rd_issue) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_cnt <= rd_cnt - 1'b1;
                end
                ram_vld <= rd_issue | (ram_vld & ~rd_load);
                if (rd_load) out_cnt <= out_cnt + 1'b1;
            end
            if (rd_load) begin
                rd_valid  <= 1'b1;
                rd_last   <= out_cnt == LAST_C;
                rd_data_l <= ram_q[FW-1 -: SAMPLE_WIDTH];
                rd_data_r <= ram_q[SAMPLE_WIDTH-1:0];
            end else if (rd_xfer) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

`ifdef I2S_CAP_FRAME_CNT_EN
    logic [31:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            trig_frame_o <= '0;
        end else begin
            if (frame_stb) frame_cnt <= frame_cnt + 1'b1;
            if (trig_hit)  trig_frame_o <= frame_cnt;
        end
    end
`endif

    i2s_cap_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({l_hold, sample_in}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_i2s_trig_capture.sv
// Directed self-checking bench for i2s_trig_capture (DEPTH=16, PRE_DEPTH=4).
module tb_i2s_trig_capture;
    import i2s_cap_pkg::*;

    localparam int SW    = 32;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic          clk, rst_n, sel_lr, arm, force_trig, trig_slope, rd_ready;
    logic [SW-1:0] sample_in, trig_level;
    logic          rd_valid, rd_last, busy;
    logic [SW-1:0] rd_data_l, rd_data_r;
    logic [2:0]    state_o;
`ifdef I2S_CAP_FRAME_CNT_EN
    logic [31:0]   trig_frame_o;
`endif

    int checks = 0;
    int passed = 0;
    int exp_l [DEPTH];
    int exp_r [DEPTH];

    i2s_trig_capture #(
        .SAMPLE_WIDTH (SW),
        .DEPTH        (DEPTH),
        .PRE_DEPTH    (PRE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sel_lr       (sel_lr),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data_l    (rd_data_l),
        .rd_data_r    (rd_data_r),
        .rd_last      (rd_last),
        .state_o      (state_o),
`ifdef I2S_CAP_FRAME_CNT_EN
        .trig_frame_o (trig_frame_o),
`endif
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic left, input int value);
        sel_lr    = left;
        sample_in = value;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int l, input int r);
        send_word(1'b1, l);
        send_word(1'b0, r);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Drains one window; every valid cycle is compared against the frame the
    // consumer is currently owed, so stalls, duplicates and drops all show up.
    task automatic collect(input string name, input bit stall);
        int idx = 0;
        int cyc = 0;
        bit seen = 0;
        checks++;
        if (state_o !== 3'd4 || rd_valid !== 1'b0)
            $display("FAIL %s_enter_readout: state=%0d valid=%0b want state=4 valid=0", name, state_o, rd_valid);
        else passed++;
        while (idx < DEPTH && cyc < 300) begin
            @(negedge clk);
            cyc++;
            rd_ready = stall ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
            if (rd_valid) begin
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (cyc != 1) $display("FAIL %s_first_valid: cycle %0d want 1", name, cyc);
                    else passed++;
                end
                checks++;
                if (rd_data_l !== 32'(exp_l[idx]))
                    $display("FAIL %s_l[%0d]: got %h want %h", name, idx, rd_data_l, 32'(exp_l[idx]));
                else passed++;
                checks++;
                if (rd_data_r !== 32'(exp_r[idx]))
                    $display("FAIL %s_r[%0d]: got %h want %h", name, idx, rd_data_r, 32'(exp_r[idx]));
                else passed++;
                checks++;
                if (rd_last !== (idx == DEPTH - 1))
                    $display("FAIL %s_last[%0d]: got %0b want %0b", name, idx, rd_last, idx == DEPTH - 1);
                else passed++;
                if (rd_ready) idx++;
            end
        end
        if (idx < DEPTH) begin
            checks++;
            $display("FAIL %s_timeout: transferred %0d want %0d", name, idx, DEPTH);
        end
        @(negedge clk);
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || state_o !== 3'd0 || busy !== 1'b0)
            $display("FAIL %s_done: valid=%0b state=%0d busy=%0b want 0/0/0", name, rd_valid, state_o, busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_valid, rd_last, busy, state_o} !== 6'd0 || rd_data_l !== '0 || rd_data_r !== '0)
            $display("FAIL reset_outputs: valid=%0b last=%0b busy=%0b state=%0d l=%h r=%h want all 0",
                     rd_valid, rd_last, busy, state_o, rd_data_l, rd_data_r);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || busy !== 1'b0)
            $display("FAIL reset_idle: state=%0d busy=%0b want 0/0", state_o, busy);
        else passed++;
    endtask

    // Ramp L=0,10,20..., R=L+1; trigger on L=60. With abort set, reset in POST.
    task automatic test_ramp(input string name, input bit abort);
        trig_level = 55;
        trig_slope = SLOPE_RISE;
        send_frame(0, 1);
        send_frame(10, 11);
        do_arm();
        checks++;
        if (state_o !== 3'd1 || busy !== 1'b1)
            $display("FAIL %s_armed: state=%0d busy=%0b want 1/1", name, state_o, busy);
        else passed++;
        for (int k = 0; k < DEPTH; k++) begin
            send_frame(20 + 10 * k, 21 + 10 * k);
            exp_l[k] = 20 + 10 * k;
            exp_r[k] = 21 + 10 * k;
            if (k == 3) begin
                checks++;
                if (state_o !== 3'd2) $display("FAIL %s_wait: state=%0d want 2", name, state_o);
                else passed++;
            end
            if (k == 4) begin
                checks++;
                if (state_o !== 3'd3) $display("FAIL %s_post: state=%0d want 3", name, state_o);
                else passed++;
            end
            if (abort && k == 7) begin
                rst_n  = 1'b0;
                sel_lr = 1'b0;
                #1;
                checks++;
                if (state_o !== 3'd0 || busy !== 1'b0 || rd_valid !== 1'b0)
                    $display("FAIL %s_async_reset: state=%0d busy=%0b valid=%0b want 0/0/0",
                             name, state_o, busy, rd_valid);
                else passed++;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
        end
        collect(name, 1'b0);
    endtask

    task automatic test_falling();
        trig_level = -5;
        trig_slope = SLOPE_FALL;
        do_arm();
        for (int k = 0; k <= DEPTH; k++) begin
            send_frame((k % 2 == 0) ? 0 : -10, 100 + k);
            if (k == 4) begin
                checks++;
                if (state_o !== 3'd2) $display("FAIL falling_no_rise_trig: state=%0d want 2", state_o);
                else passed++;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_l[i] = ((i + 1) % 2 == 0) ? 0 : -10;
            exp_r[i] = 101 + i;
        end
        collect("falling", 1'b0);
    endtask

    // Crossing at ARMED frame 2 must be ignored; next crossing (frame 5) triggers.
    task automatic test_armed_cross_stall();
        int lv [DEPTH+1];
        trig_level = 55;
        trig_slope = SLOPE_RISE;
        for (int k = 0; k <= DEPTH; k++) lv[k] = 10 * k;
        lv[0] = 0; lv[1] = 0; lv[2] = 100; lv[3] = 0; lv[4] = 0; lv[5] = 100;
        do_arm();
        for (int k = 0; k <= DEPTH; k++) begin
            send_frame(lv[k], 1000 + k);
            if (k == 4) begin
                checks++;
                if (state_o !== 3'd2) $display("FAIL armed_cross_ignored: state=%0d want 2", state_o);
                else passed++;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_l[i] = lv[i + 1];
            exp_r[i] = 1001 + i;
        end
        collect("stall", 1'b1);
    endtask

    // Pending left dropped by arm, stray right discarded, then force_trig.
    task automatic test_align_force();
        trig_level = 32'h7fff_ffff;
        trig_slope = SLOPE_RISE;
        send_word(1'b1, 5);
        do_arm();
        send_word(1'b0, 77);
        send_frame(7, 3);
        exp_l[0] = 7;
        exp_r[0] = 3;
        for (int k = 1; k < DEPTH; k++) begin
            if (k == 4) begin
                force_trig = 1'b1;
                @(negedge clk);
                force_trig = 1'b0;
                checks++;
                if (state_o !== 3'd2) $display("FAIL force_waits_for_frame: state=%0d want 2", state_o);
                else passed++;
            end
            send_frame(k, 500 + k);
            exp_l[k] = k;
            exp_r[k] = 500 + k;
            if (k == 4) begin
                checks++;
                if (state_o !== 3'd3) $display("FAIL force_trig: state=%0d want 3", state_o);
                else passed++;
            end
        end
        collect("align", 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sel_lr     = 1'b0;
        sample_in  = '0;
        arm        = 1'b0;
        force_trig = 1'b0;
        trig_level = '0;
        trig_slope = SLOPE_RISE;
        rd_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_ramp("back_to_back", 1'b0);
        test_falling();
        test_armed_cross_stall();
        test_align_force();
        test_ramp("post_reset", 1'b1);
        test_ramp("after_reset", 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
